// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS memory path.
package mips_pkg;

    // Memory interface transaction states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    // Instruction field positions.
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    // Default datapath / address / memory data width.
    localparam int DEFAULT_WIDTH = 8;

    // Default abort limit, in BUSY cycles without acknowledge.
    localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/instr_reg.sv
// 32-bit instruction register built from four byte lanes.
// Each set bit of load_i writes data_i into its lane; clr_n_i low clears all lanes.
module instr_reg (
    input  logic        clk,
    input  logic        clr_n_i,
    input  logic [3:0]  load_i,
    input  logic [7:0]  data_i,
    output logic [31:0] instr_o
);

    logic [31:0] instr_q;

    // Byte-lane load with synchronous clear.
    always_ff @(posedge clk) begin
        if (!clr_n_i) begin
            instr_q <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load_i[k]) begin
                    instr_q[8*k +: 8] <= data_i;
                end
            end
        end
    end

    assign instr_o = instr_q;

endmodule

// File: rtl/mem_if.sv
// Memory interface stage between the multicycle controller and a byte-wide memory.
// Converts controller strobes into a registered req/ack transaction, stalls the
// controller while the access is outstanding, and assembles the 32-bit instruction.
// Optional feature: define MEM_TIMEOUT_EN to abort an access after TIMEOUT BUSY
// cycles without acknowledge and raise the sticky mem_err flag.
module mem_if
    import mips_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread,
    input  logic             memwrite,
    input  logic             iord,
    input  logic [3:0]       irwrite,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] aluout,
    input  logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             stall,
    output logic [WIDTH-1:0] memdata,
    output logic [31:0]      instr,
    output logic [5:0]       op,
    output logic [5:0]       funct,
    output logic             mem_err
);

    mem_state_e       state_q, state_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] memdata_q, memdata_d;
    logic [3:0]       mask_q, mask_d;
    logic [3:0]       lane_load;
    logic             access;

`ifdef MEM_TIMEOUT_EN
    logic [3:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    // Any controller strobe starts an access when the stage is idle.
    assign access = memread | memwrite;

    // Next-state, captured request fields and stall.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        memdata_d = memdata_q;
        mask_d    = mask_q;
        lane_load = 4'b0000;
        stall     = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif

        case (state_q)
            IDLE: begin
                stall = access;
                if (access) begin
                    addr_d  = iord ? aluout : pc;
                    we_d    = memwrite;
                    wdata_d = writedata;
                    // A write never loads instruction lanes, even if irwrite is set.
                    mask_d  = memwrite ? 4'b0000 : irwrite;
                    req_d   = 1'b1;
                    state_d = BUSY;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = 4'd0;
`endif
                end
            end

            BUSY: begin
                stall = 1'b1;
                if (mem_ack) begin
                    if (!we_q) begin
                        memdata_d = mem_rdata;
                        lane_load = mask_q;
                    end
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == 4'(TIMEOUT - 1)) begin
                    // Abort: data registers stay as they were.
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
`endif
            end

            DONE: begin
                // Controller advances on this edge; strobes here are stale.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values of the others; the reset is sampled on the edge.
        if (!reset) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            memdata_q <= '0;
            mask_q    <= 4'b0000;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            memdata_q <= memdata_d;
            mask_q    <= mask_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Timeout counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= 4'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign mem_err = err_q;
`else
    assign mem_err = 1'b0;
`endif

    // Reset also clears partially fetched instruction bytes.
    instr_reg u_instr_reg (
        .clk     (clk),
        .clr_n_i (reset),
        .load_i  (lane_load),
        .data_i  (mem_rdata[7:0]),
        .instr_o (instr)
    );

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign memdata   = memdata_q;
    assign op        = instr[OP_MSB:OP_LSB];
    assign funct     = instr[FUNCT_MSB:FUNCT_LSB];

endmodule
